// File: rtl/next_pro_writer.sv
// Collects per-lane next-partition and proposal results for one batch, then writes one word to each
// of the next and proposal SRAMs (with a per-lane bytemask) when the worker signals batch end.
module next_pro_writer #(
  parameter int unsigned Q               = 16,
  parameter int unsigned NEXT_BW         = 4,
  parameter int unsigned PRO_BW          = 8,
  parameter int unsigned NEXT_ADDR_SPACE = 4,
  parameter int unsigned PRO_ADDR_SPACE  = 4,
  parameter int unsigned BATCH_BW        = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [BATCH_BW-1:0]        batch_num,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [$clog2(Q)-1:0]       in_lane,
  input  logic [NEXT_BW-1:0]         in_next,
  input  logic [PRO_BW-1:0]          in_pro,
  input  logic                       batch_finish,
  output logic                       next_sram_wsb,
  output logic [NEXT_ADDR_SPACE-1:0] next_sram_waddr,
  output logic [Q*NEXT_BW-1:0]       next_sram_wdata,
  output logic [Q-1:0]               next_sram_bytemask,
  output logic                       pro_sram_wsb,
  output logic [PRO_ADDR_SPACE-1:0]  pro_sram_waddr,
  output logic [Q*PRO_BW-1:0]        pro_sram_wdata,
  output logic [Q-1:0]               pro_sram_bytemask,
  output logic                       done
);

  typedef enum logic [0:0] {StCollect, StFlush} state_e;

  state_e                     state_q, state_d;
  logic [Q*NEXT_BW-1:0]       next_buf_q, next_buf_d;
  logic [Q*PRO_BW-1:0]        pro_buf_q, pro_buf_d;
  logic [Q-1:0]               mask_q, mask_d;
  logic                       wsb_q, wsb_d;
  logic                       done_q, done_d;
  logic [NEXT_ADDR_SPACE-1:0] next_waddr_q, next_waddr_d;
  logic [PRO_ADDR_SPACE-1:0]  pro_waddr_q, pro_waddr_d;
  logic [Q*NEXT_BW-1:0]       next_wdata_q, next_wdata_d;
  logic [Q*PRO_BW-1:0]        pro_wdata_q, pro_wdata_d;
  logic [Q-1:0]               bytemask_q, bytemask_d;
  logic                       accept;

  assign in_ready = en & (state_q == StCollect);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d      = state_q;
    next_buf_d   = next_buf_q;
    pro_buf_d    = pro_buf_q;
    mask_d       = mask_q;
    wsb_d        = 1'b1;
    done_d       = 1'b0;
    next_waddr_d = next_waddr_q;
    pro_waddr_d  = pro_waddr_q;
    next_wdata_d = next_wdata_q;
    pro_wdata_d  = pro_wdata_q;
    bytemask_d   = bytemask_q;

    // Merged view includes a beat accepted on the same edge as batch_finish.
    if (accept) begin
      next_buf_d[in_lane*NEXT_BW +: NEXT_BW] = in_next;
      pro_buf_d[in_lane*PRO_BW +: PRO_BW]    = in_pro;
      mask_d[in_lane]                        = 1'b1;
    end

    unique case (state_q)
      StCollect: begin
        if (batch_finish) begin
          next_wdata_d = next_buf_d;
          pro_wdata_d  = pro_buf_d;
          bytemask_d   = mask_d;
          next_waddr_d = batch_num[NEXT_ADDR_SPACE-1:0];
          pro_waddr_d  = batch_num[PRO_ADDR_SPACE-1:0];
          wsb_d        = ~(|mask_d);
          state_d      = StFlush;
        end
      end
      StFlush: begin
        next_buf_d = '0;
        pro_buf_d  = '0;
        mask_d     = '0;
        done_d     = 1'b1;
        state_d    = StCollect;
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StCollect;
      next_buf_q   <= '0;
      pro_buf_q    <= '0;
      mask_q       <= '0;
      wsb_q        <= 1'b1;
      done_q       <= 1'b0;
      next_waddr_q <= '0;
      pro_waddr_q  <= '0;
      next_wdata_q <= '0;
      pro_wdata_q  <= '0;
      bytemask_q   <= '0;
    end else begin
      state_q      <= state_d;
      next_buf_q   <= next_buf_d;
      pro_buf_q    <= pro_buf_d;
      mask_q       <= mask_d;
      wsb_q        <= wsb_d;
      done_q       <= done_d;
      next_waddr_q <= next_waddr_d;
      pro_waddr_q  <= pro_waddr_d;
      next_wdata_q <= next_wdata_d;
      pro_wdata_q  <= pro_wdata_d;
      bytemask_q   <= bytemask_d;
    end
  end

  assign next_sram_wsb      = wsb_q;
  assign pro_sram_wsb       = wsb_q;
  assign next_sram_waddr    = next_waddr_q;
  assign pro_sram_waddr     = pro_waddr_q;
  assign next_sram_wdata    = next_wdata_q;
  assign pro_sram_wdata     = pro_wdata_q;
  assign next_sram_bytemask = bytemask_q;
  assign pro_sram_bytemask  = bytemask_q;
  assign done               = done_q;

endmodule

// File: tb/tb_next_pro_writer.sv
// Bench for next_pro_writer: directed batch table plus random batches, checked by a done-driven
// scoreboard that also verifies the write-strobe pulse lands on the cycle before done.
module tb_next_pro_writer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic [7:0]   batch_num = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_lane = '0;
  logic [3:0]   in_next = '0;
  logic [7:0]   in_pro = '0;
  logic         batch_finish = 1'b0;
  logic         next_sram_wsb, pro_sram_wsb, done;
  logic [3:0]   next_sram_waddr, pro_sram_waddr;
  logic [63:0]  next_sram_wdata;
  logic [127:0] pro_sram_wdata;
  logic [15:0]  next_sram_bytemask, pro_sram_bytemask;

  next_pro_writer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .en                 (en),
    .batch_num          (batch_num),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_lane            (in_lane),
    .in_next            (in_next),
    .in_pro             (in_pro),
    .batch_finish       (batch_finish),
    .next_sram_wsb      (next_sram_wsb),
    .next_sram_waddr    (next_sram_waddr),
    .next_sram_wdata    (next_sram_wdata),
    .next_sram_bytemask (next_sram_bytemask),
    .pro_sram_wsb       (pro_sram_wsb),
    .pro_sram_waddr     (pro_sram_waddr),
    .pro_sram_wdata     (pro_sram_wdata),
    .pro_sram_bytemask  (pro_sram_bytemask),
    .done               (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               n;
    logic [7:0]       bn;
    logic [15:0][3:0] lane;
    logic [15:0][3:0] nx;
    logic [15:0][7:0] pr;
    logic             wr;
    logic [3:0]       addr;
    logic [63:0]      exp_next;
    logic [127:0]     exp_pro;
    logic [15:0]      exp_mask;
  } vec_t;

  typedef struct {
    logic         wr;
    logic [3:0]   addr;
    logic [63:0]  nx;
    logic [127:0] pr;
    logic [15:0]  m;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Scoreboard: each done pops one batch; the strobe must have been low exactly on the prior cycle.
  logic         low_prev;
  int           low_cnt;
  logic [3:0]   cap_naddr, cap_paddr;
  always @(negedge clk) begin
    if (!rst_n) begin
      low_prev = 1'b0;
      low_cnt  = 0;
    end else begin
      if (next_sram_wsb !== pro_sram_wsb) chk("wsb_pair", 128'(pro_sram_wsb), 128'(next_sram_wsb));
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 128'(done), 128'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wsb_pulse_prev", 128'(low_prev), 128'(e.wr));
          chk("wsb_pulse_cnt", 128'(low_cnt), 128'(e.wr));
          chk("wsb_high_at_done", 128'(next_sram_wsb), 128'd1);
          chk("next_wdata", 128'(next_sram_wdata), 128'(e.nx));
          chk("pro_wdata", pro_sram_wdata, e.pr);
          chk("next_mask", 128'(next_sram_bytemask), 128'(e.m));
          chk("pro_mask", 128'(pro_sram_bytemask), 128'(e.m));
          if (e.wr) begin
            chk("next_waddr", 128'(cap_naddr), 128'(e.addr));
            chk("pro_waddr", 128'(cap_paddr), 128'(e.addr));
          end
        end
        low_cnt = 0;
      end
      low_prev = (next_sram_wsb == 1'b0);
      if (low_prev) begin
        low_cnt++;
        cap_naddr = next_sram_waddr;
        cap_paddr = pro_sram_waddr;
      end
    end
  end

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.wr = v.wr; e.addr = v.addr; e.nx = v.exp_next; e.pr = v.exp_pro; e.m = v.exp_mask;
    exp_q.push_back(e);
  endtask

  // Drives beats back to back with batch_finish on the last one, then idles through the flush.
  task automatic apply(input vec_t v);
    int cnt;
    cnt = (v.n == 0) ? 1 : v.n;
    batch_num = v.bn;
    for (int i = 0; i < cnt; i++) begin
      in_valid     = (v.n != 0);
      in_lane      = v.lane[i];
      in_next      = v.nx[i];
      in_pro       = v.pr[i];
      batch_finish = (i == cnt - 1);
      if (batch_finish) push_exp(v);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    batch_finish = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.exp_next = '0; r.exp_pro = '0; r.exp_mask = '0;
    for (int i = 0; i < v.n; i++) begin
      r.exp_next[v.lane[i]*4 +: 4] = v.nx[i];
      r.exp_pro[v.lane[i]*8 +: 8]  = v.pr[i];
      r.exp_mask[v.lane[i]]        = 1'b1;
    end
    r.wr   = (v.n != 0);
    r.addr = v.bn[3:0];
    return r;
  endfunction

  vec_t tbl[4];

  initial begin
    vec_t v;
    // Directed table: full batch, sparse batch, duplicate lane, empty batch.
    tbl[0] = '{n: 16, bn: 8'h03, lane: '0, nx: '0, pr: '0, wr: 1'b1, addr: 4'h3,
               exp_next: 64'hFEDC_BA98_7654_3210,
               exp_pro: 128'h1F1E_1D1C_1B1A_1918_1716_1514_1312_1110, exp_mask: 16'hFFFF};
    for (int i = 0; i < 16; i++) begin
      tbl[0].lane[i] = 4'(i);
      tbl[0].nx[i]   = 4'(i);
      tbl[0].pr[i]   = 8'(8'h10 + i);
    end
    tbl[1] = '{n: 2, bn: 8'h17, lane: '0, nx: '0, pr: '0, wr: 1'b1, addr: 4'h7,
               exp_next: 64'h0000_0050_0000_0A00,
               exp_pro: 128'h0000_0000_0000_9900_0000_0000_0022_0000, exp_mask: 16'h0204};
    tbl[1].lane[0] = 4'd2; tbl[1].nx[0] = 4'hA; tbl[1].pr[0] = 8'h22;
    tbl[1].lane[1] = 4'd9; tbl[1].nx[1] = 4'h5; tbl[1].pr[1] = 8'h99;
    tbl[2] = '{n: 2, bn: 8'h42, lane: '0, nx: '0, pr: '0, wr: 1'b1, addr: 4'h2,
               exp_next: 64'h0000_0000_00C0_0000,
               exp_pro: 128'h0000_0000_0000_0000_0000_5500_0000_0000, exp_mask: 16'h0020};
    tbl[2].lane[0] = 4'd5; tbl[2].nx[0] = 4'h3; tbl[2].pr[0] = 8'hAA;
    tbl[2].lane[1] = 4'd5; tbl[2].nx[1] = 4'hC; tbl[2].pr[1] = 8'h55;
    tbl[3] = '{n: 0, bn: 8'h09, lane: '0, nx: '0, pr: '0, wr: 1'b0, addr: 4'h9,
               exp_next: 64'h0, exp_pro: 128'h0, exp_mask: 16'h0};

    // Reset state
    #12;
    chk("rst_wsb", 128'(next_sram_wsb), 128'd1);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_mask", 128'(next_sram_bytemask), 128'd0);
    chk("rst_wdata", 128'(next_sram_wdata), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_idle", 128'(in_ready), 128'd1);

    apply(tbl[0]);

    // Reset mid-collect after 5 beats: buffered data is dropped and outputs clear at once.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_lane = 4'(i); in_next = 4'(i + 1); in_pro = 8'(i + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_wsb", 128'(next_sram_wsb), 128'd1);
    chk("midrst_mask", 128'(pro_sram_bytemask), 128'd0);
    chk("midrst_wdata", pro_sram_wdata, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    v = tbl[3]; v.bn = 8'h05;
    apply(v);

    for (int k = 1; k < 4; k++) apply(tbl[k]);

    // in_valid and batch_finish held through FLUSH: ignored there, beat lands in the next batch.
    v = tbl[3]; v.n = 1; v.bn = 8'h21; v.lane[0] = 4'd0; v.nx[0] = 4'h1; v.pr[0] = 8'h01;
    v = model(v);
    batch_num = v.bn; in_valid = 1'b1; in_lane = 4'd0; in_next = 4'h1; in_pro = 8'h01;
    batch_finish = 1'b1;
    push_exp(v);
    @(posedge clk); #1;
    in_lane = 4'd7; in_next = 4'hE; in_pro = 8'h77;
    @(negedge clk);
    chk("flush_ready", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    batch_finish = 1'b0;
    @(negedge clk);
    chk("post_flush_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; batch_finish = 1'b1; batch_num = 8'h22;
    v = tbl[3]; v.n = 1; v.bn = 8'h22; v.lane[0] = 4'd7; v.nx[0] = 4'hE; v.pr[0] = 8'h77;
    v.wr = 1'b1; v.addr = 4'h2; v.exp_next = 64'h0000_0000_E000_0000;
    v.exp_pro = 128'h0000_0000_0000_0000_7700_0000_0000_0000; v.exp_mask = 16'h0080;
    push_exp(v);
    @(posedge clk); #1;
    batch_finish = 1'b0;
    @(posedge clk); #1;

    // en=0: beat refused but batch_finish still flushes an empty batch.
    en = 1'b0; in_valid = 1'b1; in_lane = 4'd3; in_next = 4'h6; in_pro = 8'h66;
    batch_finish = 1'b1; batch_num = 8'h04;
    v = tbl[3]; v.bn = 8'h04; v.addr = 4'h4;
    push_exp(v);
    @(negedge clk);
    chk("en0_ready", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; batch_finish = 1'b0; en = 1'b1;
    @(posedge clk); #1;

    // Random batches checked against the behavioural model.
    for (int k = 0; k < 3; k++) begin
      v = tbl[3];
      v.n = $urandom_range(1, 16);
      v.bn = 8'($urandom);
      for (int i = 0; i < v.n; i++) begin
        v.lane[i] = 4'($urandom); v.nx[i] = 4'($urandom); v.pr[i] = 8'($urandom);
      end
      apply(model(v));
    end

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    if (exp_q.size() != 0) chk("drain", 128'(exp_q.size()), 128'd0);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
